flexbex_ibex_instr_mem_responder: RTL and testbench

//  Responder end of the core instruction-fetch req/gnt/rvalid interface. Grants fetch requests,

---
 rtl/flexbex_imem_pkg.sv | 16 +
 rtl/flexbex_imem_resp_pipe.sv | 63 ++++++
 rtl/flexbex_ibex_instr_mem_responder.sv | 95 +++++++++
 tb/tb_flexbex_ibex_instr_mem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flexbex_imem_pkg.sv
// Shared constants and types for the instruction-memory responder.
// LFSR constants apply only when FLEXBEX_IMEM_RAND_STALL_EN is defined.
package flexbex_imem_pkg;

   localparam int unsigned MAX_RESP_LAT = 4;

   // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic valid;
      logic oob;
   } resp_ent_t;

endpackage

// File: rtl/flexbex_imem_resp_pipe.sv
// Response pipeline: RESP_LAT-deep {valid, oob} shift register plus data
// stages fed from the SRAM output; OOB_FILL substituted at the output.
module flexbex_imem_resp_pipe
   import flexbex_imem_pkg::*;
#(
   parameter int unsigned RESP_LAT = 1,
   parameter logic [31:0] OOB_FILL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_oob,
   input  logic [31:0] sram_rdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o
);

   resp_ent_t   ent_q [RESP_LAT];
   logic [31:0] out_raw;
   logic [31:0] out_data;
   logic [31:0] hold_q;
   logic        out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RESP_LAT; i++) ent_q[i] <= '0;
      end else begin
         ent_q[0] <= '{valid: in_valid, oob: in_oob};
         for (int i = 1; i < RESP_LAT; i++) ent_q[i] <= ent_q[i-1];
      end
   end

   if (RESP_LAT == 1) begin : g_direct
      assign out_raw = sram_rdata_i;
   end else begin : g_stages
      // dat_q[i] travels alongside ent_q[i+1]
      logic [31:0] dat_q [RESP_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < RESP_LAT - 1; i++) dat_q[i] <= '0;
         end else begin
            if (ent_q[0].valid) dat_q[0] <= sram_rdata_i;
            for (int i = 1; i < RESP_LAT - 1; i++)
               if (ent_q[i].valid) dat_q[i] <= dat_q[i-1];
         end
      end

      assign out_raw = dat_q[RESP_LAT-2];
   end

   assign out_valid = ent_q[RESP_LAT-1].valid;
   assign out_data  = ent_q[RESP_LAT-1].oob ? OOB_FILL : out_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         hold_q <= '0;
      else if (out_valid) hold_q <= out_data;
   end

   assign rvalid_o = out_valid;
   assign rdata_o  = out_valid ? out_data : hold_q;

endmodule

// File: rtl/flexbex_ibex_instr_mem_responder.sv
// Fetch-side req/gnt/rvalid responder in front of a synchronous SRAM.
// Optional random grant stall: define FLEXBEX_IMEM_RAND_STALL_EN.
module flexbex_ibex_instr_mem_responder
   import flexbex_imem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned RESP_LAT  = 1,
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [31:0] OOB_FILL  = 32'h0000_0000,
   localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_req_i,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_gnt_o,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   output logic          sram_req_o,
   output logic [AW-1:0] sram_addr_o,
   input  logic [31:0]   sram_rdata_i,
   output logic          range_err_o,
   output logic          busy_o
);

   localparam int unsigned    CW      = $clog2(MAX_OUTST + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTST);

   logic [CW-1:0] cnt_q;
   logic          stall;
   logic          in_range;
   logic          range_err_q;
   logic [32:0]   addr_x;
   logic [32:0]   lo_x;
   logic [32:0]   hi_x;
   logic [31:0]   word_off;

   // 33-bit compare so a range ending at 2^32 does not wrap
   assign addr_x   = {1'b0, instr_addr_i};
   assign lo_x     = {1'b0, ADDR_BASE};
   assign hi_x     = lo_x + ({1'b0, 32'(MEM_WORDS)} << 2);
   assign in_range = (addr_x >= lo_x) && (addr_x < hi_x);

   assign word_off    = instr_addr_i - ADDR_BASE;
   assign sram_addr_o = AW'(word_off >> 2);

   assign instr_gnt_o = instr_req_i && (cnt_q < CNT_MAX) && !stall;
   assign sram_req_o  = instr_gnt_o && in_range;

`ifdef FLEXBEX_IMEM_RAND_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   flexbex_imem_resp_pipe #(
      .RESP_LAT (RESP_LAT),
      .OOB_FILL (OOB_FILL)
   ) u_resp_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (instr_gnt_o),
      .in_oob       (!in_range),
      .sram_rdata_i (sram_rdata_i),
      .rvalid_o     (instr_rvalid_o),
      .rdata_o      (instr_rdata_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (instr_gnt_o && !instr_rvalid_o) begin
         cnt_q <= cnt_q + CW'(1);
      end else if (!instr_gnt_o && instr_rvalid_o) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        range_err_q <= 1'b0;
      else if (instr_gnt_o && !in_range) range_err_q <= 1'b1;
   end

   assign range_err_o = range_err_q;
   assign busy_o      = (cnt_q != '0);

endmodule

// File: tb/tb_flexbex_ibex_instr_mem_responder.sv
// Scoreboard bench for the instruction-memory responder (RESP_LAT=2,
// MAX_OUTST=2); a negedge monitor checks every cycle against a queue.
module tb_flexbex_ibex_instr_mem_responder;

   localparam int          LAT  = 2;
   localparam int          MAXO = 2;
   localparam int          AW   = 10;
   localparam logic [31:0] OOBV = 32'hDEAD_0013;

   logic          clk;
   logic          rst_n;
   logic          req;
   logic [31:0]   addr;
   logic          gnt;
   logic          rvalid;
   logic [31:0]   rdata;
   logic          sram_req;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_rdata;
   logic          range_err;
   logic          busy;

   flexbex_ibex_instr_mem_responder #(
      .ADDR_BASE (32'h0000_0000),
      .MEM_WORDS (1024),
      .RESP_LAT  (LAT),
      .MAX_OUTST (MAXO),
      .OOB_FILL  (OOBV)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_req_i    (req),
      .instr_addr_i   (addr),
      .instr_gnt_o    (gnt),
      .instr_rvalid_o (rvalid),
      .instr_rdata_o  (rdata),
      .sram_req_o     (sram_req),
      .sram_addr_o    (sram_addr),
      .sram_rdata_i   (sram_rdata),
      .range_err_o    (range_err),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input int idx);
      if (idx == 4) return 32'hDEAD_BEEF;
      return 32'h1000_0000 + idx * 32'h0003_0001;
   endfunction

   // SRAM data is only meaningful the cycle after a read
   always @(posedge clk) begin
      if (sram_req) sram_rdata <= mem_word(int'(sram_addr));
      else          sram_rdata <= 32'hBAD0_BAD0;
   end

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          mcnt  = 0;
   logic        merr  = 1'b0;
   logic [31:0] mlast = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic  exp_gnt;
      logic  exp_rv;
      logic  inr;
      exp_t  e;
      if (!rst_n) begin
         chk("rst_gnt", 32'(gnt), 0);
         chk("rst_rvalid", 32'(rvalid), 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_sram_req", 32'(sram_req), 0);
         chk("rst_range_err", 32'(range_err), 0);
         chk("rst_busy", 32'(busy), 0);
         q.delete();
         mcnt  = 0;
         merr  = 1'b0;
         mlast = 32'h0;
      end else begin
         exp_gnt = req && (mcnt < MAXO);
`ifdef FLEXBEX_IMEM_RAND_STALL_EN
         chk("gnt_legal", 32'(gnt && !exp_gnt), 0);
`else
         chk("gnt", 32'(gnt), 32'(exp_gnt));
`endif
         chk("range_err", 32'(range_err), 32'(merr));
         chk("busy", 32'(busy), 32'(mcnt != 0));
         exp_rv = (q.size() > 0) && (q[0].cyc == cyc);
         chk("rvalid", 32'(rvalid), 32'(exp_rv));
         if (exp_rv) begin
            e = q.pop_front();
            chk("rdata", rdata, e.data);
            mlast = e.data;
         end else begin
            chk("rdata_hold", rdata, mlast);
         end
         if (gnt) begin
            inr = (addr < 32'h0000_1000);
            chk("sram_req", 32'(sram_req), 32'(inr));
            if (inr) chk("sram_addr", 32'(sram_addr), addr >> 2);
            e.data = inr ? mem_word(int'(addr >> 2)) : OOBV;
            e.cyc  = cyc + LAT;
            q.push_back(e);
            if (!inr) merr = 1'b1;
         end else begin
            chk("sram_req_idle", 32'(sram_req), 0);
         end
         mcnt = mcnt + int'(gnt) - int'(exp_rv);
      end
   end

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] a, output logic [31:0] sa,
                        output logic sr);
      bit got = 1'b0;
      req  = 1'b1;
      addr = a;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         got = gnt;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL fetch_timeout addr %h: got no grant expected grant", a);
      end
      sa = 32'(sram_addr);
      sr = sram_req;
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   logic [31:0] sa;
   logic        sr;

   initial begin
      int nrand;
      rst_n = 1'b0;
      req   = 1'b0;
      addr  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // single fetch of mem[4]
      fetch(32'h0000_0010, sa, sr);
      chk("t1_sram_addr", sa, 32'h4);
      idle(4);

      // edges of the address window
      fetch(32'h0000_0FFC, sa, sr);
      chk("edge_last_req", 32'(sr), 1);
      chk("edge_last_addr", sa, 32'h3FF);
      idle(4);
      chk("edge_no_err", 32'(range_err), 0);

`ifndef FLEXBEX_IMEM_RAND_STALL_EN
      begin : t2
         logic [31:0] al [3];
         logic [3:0]  pat;
         int          ai;
         al[0] = 32'h0;
         al[1] = 32'h4;
         al[2] = 32'h8;
         pat   = 4'b1011;
         ai    = 0;
         req   = 1'b1;
         addr  = al[0];
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_gnt", 32'(gnt), 32'(pat[k]));
            if (gnt) ai++;
            @(posedge clk);
            #1;
            if (ai < 3) addr = al[ai];
            else        req = 1'b0;
         end
      end
      idle(5);

      req  = 1'b1;
      addr = 32'h0;
      @(posedge clk);
      #1;
      addr = 32'h4;
      @(posedge clk);
      #1;
      addr = 32'h20;
      @(negedge clk);
      chk("t3_gnt_low", 32'(gnt), 0);
      @(posedge clk);
      #1;
      addr = 32'h40;
      @(negedge clk);
      chk("t3_gnt", 32'(gnt), 1);
      chk("t3_sram_addr", 32'(sram_addr), 32'h10);
      @(posedge clk);
      #1;
      idle(5);
`endif

      // out-of-range fetches, including one near 2^32
      fetch(32'h0001_0000, sa, sr);
      chk("t4_sram_req", 32'(sr), 0);
      idle(4);
      chk("t4_err", 32'(range_err), 1);
      fetch(32'h0000_1000, sa, sr);
      chk("t4_top_req", 32'(sr), 0);
      fetch(32'hFFFF_FFFC, sa, sr);
      chk("t4_wrap_req", 32'(sr), 0);
      idle(6);
      chk("t4_sticky", 32'(range_err), 1);

      // reset one cycle after a grant
      fetch(32'h0000_0008, sa, sr);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(6);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_err", 32'(range_err), 0);

`ifdef FLEXBEX_IMEM_RAND_STALL_EN
      nrand = 1000;
`else
      nrand = 300;
`endif
      for (int i = 0; i < nrand; i++) begin
         req = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0)
            addr = $urandom();
         else
            addr = {20'h0, 10'($urandom_range(0, 1023)),
                    2'($urandom_range(0, 3))};
         @(posedge clk);
         #1;
      end
      req = 1'b0;

      for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
